serial_lane_tx: RTL

//  Serial frame transmitter for the four-lane serial link: latches four DATA_W-bit lane values
//  (L0..L3) and a lane mask, then emits one frame per selected lane on a single serial line.

---
 rtl/serial_lane_tx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/serial_lane_tx.sv
// Four-lane serial frame transmitter: captures lane payloads and a lane mask, then sends
// one frame (start, 2-bit lane address, data MSB first, idle gap) per selected lane.
module serial_lane_tx #(
   parameter int DATA_W = 4,
   parameter int GAP    = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Zero,
   input  logic              send,
   input  logic [3:0]        mask,
   input  logic [DATA_W-1:0] L0,
   input  logic [DATA_W-1:0] L1,
   input  logic [DATA_W-1:0] L2,
   input  logic [DATA_W-1:0] L3,
   output logic              serOut,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_ADDR,
      S_DATA,
      S_GAP
   } state_t;

   localparam int CW = $clog2(DATA_W + GAP + 2);
   localparam logic [CW-1:0] ADDR_LAST = CW'(1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

   state_t            state, state_d;
   logic [CW-1:0]     cnt, cnt_d;
   logic [1:0]        lane, lane_d;
   logic [3:0]        mask_q, mask_d;
   logic [DATA_W-1:0] data_q [4];
   logic [DATA_W-1:0] data_d [4];
   logic [DATA_W-1:0] word;
   logic [2:0]        first, nxt;
   logic              ser_d, busy_d, done_d;

   // Lowest set lane at or above index from; bit 2 set means no such lane.
   function automatic logic [2:0] pick_lane(input logic [3:0] m, input logic [2:0] from);
      pick_lane = 3'b100;
      for (int i = 3; i >= 0; i--)
         if (m[i] && (3'(i) >= from)) pick_lane = 3'(i);
   endfunction

   function automatic logic any_from(input logic [3:0] m, input logic [2:0] from);
      any_from = 1'b0;
      for (int i = 0; i < 4; i++)
         if (m[i] && (3'(i) >= from)) any_from = 1'b1;
   endfunction

   // NOTE: every variable written here gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      lane_d  = lane;
      mask_d  = mask_q;
      data_d  = data_q;
      first   = pick_lane(mask, 3'd0);
      nxt     = pick_lane(mask_q, {1'b0, lane} + 3'd1);
      done_d  = 1'b0;

      case (state)
         S_IDLE: begin
            if (send) begin
               mask_d    = mask;
               data_d[0] = L0;
               data_d[1] = L1;
               data_d[2] = L2;
               data_d[3] = L3;
               cnt_d     = '0;
               if (!first[2]) begin
                  state_d = S_START;
                  lane_d  = first[1:0];
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_START: begin
            state_d = S_ADDR;
            cnt_d   = '0;
         end
         S_ADDR: begin
            if (cnt == ADDR_LAST) begin
               state_d = S_DATA;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt == DATA_LAST) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_d = '0;
               if (!nxt[2]) begin
                  state_d = S_START;
                  lane_d  = nxt[1:0];
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered, so they are derived from the state being entered.
      word   = data_d[lane_d] << cnt_d;
      busy_d = (state_d != S_IDLE);
      case (state_d)
         S_START: ser_d = 1'b0;
         S_ADDR:  ser_d = (cnt_d == '0) ? lane_d[1] : lane_d[0];
         S_DATA:  ser_d = word[DATA_W-1];
         default: ser_d = 1'b1;
      endcase

      // done marks the final gap cycle of the last selected frame.
      if (state_d == S_GAP && cnt_d == GAP_LAST && !any_from(mask_d, {1'b0, lane_d} + 3'd1))
         done_d = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (!RST || Zero) begin
         state  <= S_IDLE;
         cnt    <= '0;
         lane   <= '0;
         mask_q <= '0;
         // NOTE: the capture store is four small registers, not a RAM, so clearing it
         // on reset is cheap and keeps abort behaviour fully deterministic.
         data_q <= '{default: '0};
         serOut <= 1'b1;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         lane   <= lane_d;
         mask_q <= mask_d;
         data_q <= data_d;
         serOut <= ser_d;
         busy   <= busy_d;
         done   <= done_d;
      end
   end

endmodule
